// File: rtl/assoc_cache_pkg.sv
// assoc_cache_pkg
// Shared definitions for the set-associative cache slice:
//   - cacheState_e : controller state encoding (CACHE_IDLE .. CACHE_WRITE)
//   - clog2        : ceiling log2, returns 0 for a value of 1 (field widths)
//   - atLeastOne   : clamps a field width to 1 so that degenerate
//                    configurations (one set, one way, one word) still
//                    declare legal vectors
package assoc_cache_pkg;

  typedef enum logic [2:0] {
    CACHE_IDLE  = 3'd0,
    CACHE_TAG   = 3'd1,
    CACHE_FILL  = 3'd2,
    CACHE_RESP  = 3'd3,
    CACHE_WRITE = 3'd4
  } cacheState_e;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int atLeastOne(input int width);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/assoc_cache_lru.sv
// assoc_cache_lru
// Per-set LRU age tracker. Every way carries an age; age 0 is the most
// recently used way and age WAYS-1 the least recently used. Ages within a
// set are always a permutation of 0..WAYS-1, so the victim is unique.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (ages -> way order)
//   touch_i      : mark way_i of set_i as most recently used this cycle
//   set_i        : set being looked up / touched
//   way_i        : way being touched
//   victim_o     : least recently used way of set_i
module assoc_cache_lru
  import assoc_cache_pkg::*;
#(
  parameter int SETS     = 4,
  parameter int WAYS     = 2,
  parameter int SET_BITS = atLeastOne(clog2(SETS)),
  parameter int WAY_BITS = atLeastOne(clog2(WAYS))
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                touch_i,
  input  logic [SET_BITS-1:0] set_i,
  input  logic [WAY_BITS-1:0] way_i,
  output logic [WAY_BITS-1:0] victim_o
);

  logic [WAY_BITS-1:0] age_q [SETS][WAYS];
  logic [WAY_BITS-1:0] touchedAge;
  logic [WAY_BITS-1:0] maxAge;

  assign touchedAge = age_q[set_i][way_i];

  // Touching a way makes it youngest; only the ways that were younger than
  // it age by one, which keeps the ages of the set a permutation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_BITS'(w);
        end
      end
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_BITS'(w) == way_i) begin
          age_q[set_i][w] <= '0;
        end else if (age_q[set_i][w] < touchedAge) begin
          age_q[set_i][w] <= age_q[set_i][w] + WAY_BITS'(1);
        end
      end
    end
  end

  // Victim is the oldest way of the addressed set.
  always_comb begin
    victim_o = '0;
    maxAge   = age_q[set_i][0];
    for (int w = 1; w < WAYS; w++) begin
      if (age_q[set_i][w] > maxAge) begin
        maxAge   = age_q[set_i][w];
        victim_o = WAY_BITS'(w);
      end
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// assoc_cache
// N-way set-associative, write-through, no-write-allocate cache with LRU
// replacement, placed between a pipeline memory port and a line-wide main
// memory. One instance serves instruction fetch, another the data side.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   readC, writeC           : client requests, held until readyC
//   address                 : client word address
//   data                    : write data in / read data out (driven only
//                             while readC && readyC)
//   readyC                  : one-cycle completion pulse
//   readM, writeM           : line fill / word write-through to memory
//   addressM                : line address (fill) or word address (write)
//   dataM                   : fill line in / write word out (low word,
//                             driven only while writeM)
//   input_readyM, doneM     : fill line valid / memory write complete
//   num_cache_access/miss   : wrapping access and miss counters
module assoc_cache
  import assoc_cache_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 4,
  parameter int WAYS       = 2,
  parameter int BYPASS     = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            readC,
  input  logic                            writeC,
  input  logic [WORD_SIZE-1:0]            address,
  inout  wire  [WORD_SIZE-1:0]            data,
  output logic                            readyC,
  output logic                            readM,
  output logic                            writeM,
  output logic [WORD_SIZE-1:0]            addressM,
  inout  wire  [LINE_WORDS*WORD_SIZE-1:0] dataM,
  input  logic                            input_readyM,
  input  logic                            doneM,
  output logic [WORD_SIZE-1:0]            num_cache_access,
  output logic [WORD_SIZE-1:0]            num_cache_miss
);

  localparam int OFF_W     = clog2(LINE_WORDS);
  localparam int IDX_W     = clog2(SETS);
  localparam int OFF_B     = atLeastOne(OFF_W);
  localparam int IDX_B     = atLeastOne(IDX_W);
  localparam int WAY_B     = atLeastOne(clog2(WAYS));
  localparam int TAG_W     = WORD_SIZE - OFF_W - IDX_W;
  localparam int LINE_BITS = LINE_WORDS * WORD_SIZE;

  cacheState_e                          state_q;
  logic [WORD_SIZE-1:0]                 addr_q;
  logic [WORD_SIZE-1:0]                 wrData_q;
  logic [WORD_SIZE-1:0]                 access_q;
  logic [WORD_SIZE-1:0]                 miss_q;
  logic                                 isWrite_q;
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] lineBuf_q;

  logic                                 valid_q    [SETS][WAYS];
  logic [TAG_W-1:0]                     tag_q      [SETS][WAYS];
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] lineData_q [SETS][WAYS];

  logic [OFF_B-1:0]     reqOffset;
  logic [IDX_B-1:0]     reqIndex;
  logic [TAG_W-1:0]     reqTag;
  logic                 hitAny;
  logic                 hit;
  logic [WAY_B-1:0]     hitWay;
  logic [WAY_B-1:0]     lruVictim;
  logic [WAY_B-1:0]     victimWay;
  logic [WAY_B-1:0]     touchWay;
  logic [WORD_SIZE-1:0] hitWord;
  logic [WORD_SIZE-1:0] respWord;
  logic                 tagStage;
  logic                 installEn;
  logic                 writeHitEn;
  logic                 touchEn;

  // Field extraction; degenerate one-word lines or single-set caches have
  // no offset/index bits, so those fields collapse to zero.
  assign reqTag = addr_q[WORD_SIZE-1 -: TAG_W];

  if (OFF_W > 0) begin : gOffset
    assign reqOffset = addr_q[OFF_W-1:0];
  end else begin : gNoOffset
    assign reqOffset = '0;
  end

  if (IDX_W > 0) begin : gIndex
    assign reqIndex = addr_q[OFF_W +: IDX_W];
  end else begin : gNoIndex
    assign reqIndex = '0;
  end

  // Tag compare across the ways of the addressed set. A bypass cache never
  // reports a hit, so it never touches the arrays either.
  always_comb begin
    hitAny = 1'b0;
    hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[reqIndex][w] && (tag_q[reqIndex][w] == reqTag)) begin
        hitAny = 1'b1;
        hitWay = WAY_B'(w);
      end
    end
  end

  assign hit     = hitAny && (BYPASS == 0);
  assign hitWord = lineData_q[reqIndex][hitWay][reqOffset];

  // Victim choice: the lowest-numbered invalid way wins over the LRU way,
  // so a cold set fills in way order before anything is evicted.
  always_comb begin
    victimWay = lruVictim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[reqIndex][w]) begin
        victimWay = WAY_B'(w);
      end
    end
  end

  assign tagStage   = (state_q == CACHE_TAG);
  assign installEn  = (state_q == CACHE_FILL) && input_readyM && (BYPASS == 0);
  assign writeHitEn = tagStage && isWrite_q && hit;
  assign touchEn    = (tagStage && hit) || installEn;
  assign touchWay   = tagStage ? hitWay : victimWay;

  assoc_cache_lru #(
    .SETS     (SETS),
    .WAYS     (WAYS),
    .SET_BITS (IDX_B),
    .WAY_BITS (WAY_B)
  ) uLru (
    .clk      (clk),
    .reset_n  (reset_n),
    .touch_i  (touchEn),
    .set_i    (reqIndex),
    .way_i    (touchWay),
    .victim_o (lruVictim)
  );

  // Tag and line storage need no reset: valid bits alone decide whether
  // their contents mean anything.
  always_ff @(posedge clk) begin
    if (installEn) begin
      tag_q[reqIndex][victimWay]      <= reqTag;
      lineData_q[reqIndex][victimWay] <= dataM;
    end
    if (writeHitEn) begin
      lineData_q[reqIndex][hitWay][reqOffset] <= wrData_q;
    end
  end

  // Controller. Every path back to IDLE passes through a state that raises
  // readyC, so a client dropping its request in the following cycle is
  // never mistaken for a fresh access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CACHE_IDLE;
      addr_q    <= '0;
      wrData_q  <= '0;
      isWrite_q <= 1'b0;
      lineBuf_q <= '0;
      access_q  <= '0;
      miss_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
        end
      end
    end else begin
      case (state_q)
        CACHE_IDLE: begin
          if (writeC || readC) begin
            addr_q    <= address;
            wrData_q  <= data;
            isWrite_q <= writeC;
            access_q  <= access_q + WORD_SIZE'(1);
            state_q   <= CACHE_TAG;
          end
        end
        CACHE_TAG: begin
          if (isWrite_q) begin
            if (!hit) begin
              miss_q <= miss_q + WORD_SIZE'(1);
            end
            state_q <= CACHE_WRITE;
          end else if (hit) begin
            state_q <= CACHE_IDLE;
          end else begin
            miss_q  <= miss_q + WORD_SIZE'(1);
            state_q <= CACHE_FILL;
          end
        end
        CACHE_FILL: begin
          if (input_readyM) begin
            lineBuf_q <= dataM;
            if (BYPASS == 0) begin
              valid_q[reqIndex][victimWay] <= 1'b1;
            end
            state_q <= CACHE_RESP;
          end
        end
        CACHE_RESP: begin
          state_q <= CACHE_IDLE;
        end
        CACHE_WRITE: begin
          if (doneM) begin
            state_q <= CACHE_RESP;
          end
        end
        default: begin
          state_q <= CACHE_IDLE;
        end
      endcase
    end
  end

  assign readyC   = (tagStage && !isWrite_q && hit) || (state_q == CACHE_RESP);
  assign respWord = tagStage ? hitWord : lineBuf_q[reqOffset];
  assign data     = (readC && readyC) ? respWord : {WORD_SIZE{1'bz}};

  assign readM    = (state_q == CACHE_FILL);
  assign writeM   = (state_q == CACHE_WRITE);
  assign addressM = writeM ? addr_q : (addr_q & ~WORD_SIZE'(LINE_WORDS - 1));
  assign dataM    = writeM ? LINE_BITS'(wrData_q) : {LINE_BITS{1'bz}};

  assign num_cache_access = access_q;
  assign num_cache_miss   = miss_q;

endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache
// Directed bench for assoc_cache: a normal 2-way instance and a BYPASS
// instance share clock and reset; a small memory responder supplies fill
// lines and write acknowledgements.
module tb_assoc_cache;

  localparam int MAX_CYCLES  = 40;
  localparam int FILL_DELAY  = 3;
  localparam int DONE_DELAY  = 2;
  localparam logic [63:0] FIXED_LINE = 64'h4444_3333_2222_1111;

  logic        clk;
  logic        reset_n;
  logic        readC        [2];
  logic        writeC       [2];
  logic        inputReadyM  [2];
  logic        doneM        [2];
  logic        readyC       [2];
  logic        readM        [2];
  logic        writeM       [2];
  logic [15:0] address      [2];
  logic [15:0] addressM     [2];
  logic [15:0] numAccess    [2];
  logic [15:0] numMiss      [2];
  logic        tbDataDrive  [2];
  logic        memDrive     [2];
  logic [15:0] tbData;
  logic [63:0] memLine;

  wire  [15:0] data0;
  wire  [15:0] data1;
  wire  [63:0] dataM0;
  wire  [63:0] dataM1;

  int          assertCount;
  int          failCount;
  int          reqCycles;
  int          fillCycle;
  int          doneCycle;
  bit          sawReadM;
  bit          sawWriteM;
  bit          timedOut;
  bit          useFixedLine;
  logic [15:0] seenFillAddr;
  logic [15:0] seenWriteAddr;
  logic [63:0] seenWriteLine;
  logic [15:0] readWord;

  assign data0  = tbDataDrive[0] ? tbData  : 16'bz;
  assign data1  = tbDataDrive[1] ? tbData  : 16'bz;
  assign dataM0 = memDrive[0]    ? memLine : 64'bz;
  assign dataM1 = memDrive[1]    ? memLine : 64'bz;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assoc_cache #(.WORD_SIZE(16), .LINE_WORDS(4), .SETS(4), .WAYS(2), .BYPASS(0)) dut (
    .clk(clk), .reset_n(reset_n), .readC(readC[0]), .writeC(writeC[0]),
    .address(address[0]), .data(data0), .readyC(readyC[0]), .readM(readM[0]),
    .writeM(writeM[0]), .addressM(addressM[0]), .dataM(dataM0),
    .input_readyM(inputReadyM[0]), .doneM(doneM[0]),
    .num_cache_access(numAccess[0]), .num_cache_miss(numMiss[0])
  );

  assoc_cache #(.WORD_SIZE(16), .LINE_WORDS(4), .SETS(4), .WAYS(2), .BYPASS(1)) dutBypass (
    .clk(clk), .reset_n(reset_n), .readC(readC[1]), .writeC(writeC[1]),
    .address(address[1]), .data(data1), .readyC(readyC[1]), .readM(readM[1]),
    .writeM(writeM[1]), .addressM(addressM[1]), .dataM(dataM1),
    .input_readyM(inputReadyM[1]), .doneM(doneM[1]),
    .num_cache_access(numAccess[1]), .num_cache_miss(numMiss[1])
  );

  // Memory contents: word k of the line at lineAddr is {lineAddr[11:4], k}.
  function automatic logic [63:0] patternLine(input logic [15:0] lineAddr);
    logic [63:0] line;
    for (int k = 0; k < 4; k++) begin
      line[k*16 +: 16] = {lineAddr[11:4], 8'(k)};
    end
    return line;
  endfunction

  task automatic applyReset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue one request on instance sel and play memory until readyC. The
  // request cycle is cycle 1; a cycle budget bounds the wait.
  task automatic applyStimulus(input int sel, input bit isWrite,
                               input logic [15:0] addr, input logic [15:0] wdata);
    int readMCount;
    int writeMCount;
    readMCount = 0;
    writeMCount = 0;
    sawReadM = 1'b0;
    sawWriteM = 1'b0;
    timedOut = 1'b1;
    reqCycles = 0;
    fillCycle = -1;
    doneCycle = -1;
    readWord = 16'h0;
    @(negedge clk);
    address[sel] = addr;
    tbData = wdata;
    readC[sel] = !isWrite;
    writeC[sel] = isWrite;
    tbDataDrive[sel] = isWrite;
    for (int cyc = 2; cyc <= MAX_CYCLES; cyc++) begin
      @(negedge clk);
      inputReadyM[sel] = 1'b0;
      doneM[sel] = 1'b0;
      memDrive[sel] = 1'b0;
      if (readyC[sel]) begin
        reqCycles = cyc;
        readWord = (sel == 1) ? data1 : data0;
        timedOut = 1'b0;
        break;
      end
      if (readM[sel]) begin
        if (!sawReadM) seenFillAddr = addressM[sel];
        sawReadM = 1'b1;
        readMCount++;
        if (readMCount == FILL_DELAY) begin
          memLine = useFixedLine ? FIXED_LINE : patternLine(addressM[sel]);
          memDrive[sel] = 1'b1;
          inputReadyM[sel] = 1'b1;
          fillCycle = cyc;
        end
      end
      if (writeM[sel]) begin
        if (!sawWriteM) begin
          seenWriteAddr = addressM[sel];
          seenWriteLine = (sel == 1) ? dataM1 : dataM0;
        end
        sawWriteM = 1'b1;
        writeMCount++;
        if (writeMCount == DONE_DELAY) begin
          doneM[sel] = 1'b1;
          doneCycle = cyc;
        end
      end
    end
    readC[sel] = 1'b0;
    writeC[sel] = 1'b0;
    tbDataDrive[sel] = 1'b0;
    inputReadyM[sel] = 1'b0;
    doneM[sel] = 1'b0;
    memDrive[sel] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyReset();
    assertCount++; if (readyC[0] !== 1'b0) begin failCount++; $display("[TB] FAIL reset_readyC: got %0b want 0", readyC[0]); end
    assertCount++; if (readM[0] !== 1'b0) begin failCount++; $display("[TB] FAIL reset_readM: got %0b want 0", readM[0]); end
    assertCount++; if (writeM[0] !== 1'b0) begin failCount++; $display("[TB] FAIL reset_writeM: got %0b want 0", writeM[0]); end
    assertCount++; if (numAccess[0] !== 16'd0) begin failCount++; $display("[TB] FAIL reset_access: got %0d want 0", numAccess[0]); end
    assertCount++; if (numMiss[0] !== 16'd0) begin failCount++; $display("[TB] FAIL reset_miss: got %0d want 0", numMiss[0]); end
    assertCount++; if (numAccess[1] !== 16'd0) begin failCount++; $display("[TB] FAIL reset_bypass_access: got %0d want 0", numAccess[1]); end
  endtask

  task automatic test_cold_read();
    useFixedLine = 1'b1;
    applyStimulus(0, 1'b0, 16'h0012, 16'h0);
    assertCount++; if (timedOut !== 1'b0) begin failCount++; $display("[TB] FAIL cold_timeout: got %0b want 0", timedOut); end
    assertCount++; if (sawReadM !== 1'b1) begin failCount++; $display("[TB] FAIL cold_readM: got %0b want 1", sawReadM); end
    assertCount++; if (seenFillAddr !== 16'h0010) begin failCount++; $display("[TB] FAIL cold_addressM: got %h want 0010", seenFillAddr); end
    assertCount++; if (reqCycles !== fillCycle + 1) begin failCount++; $display("[TB] FAIL cold_ready_cycle: got %0d want %0d", reqCycles, fillCycle + 1); end
    assertCount++; if (readWord !== 16'h3333) begin failCount++; $display("[TB] FAIL cold_data: got %h want 3333", readWord); end
    assertCount++; if (numAccess[0] !== 16'd1) begin failCount++; $display("[TB] FAIL cold_access: got %0d want 1", numAccess[0]); end
    assertCount++; if (numMiss[0] !== 16'd1) begin failCount++; $display("[TB] FAIL cold_miss: got %0d want 1", numMiss[0]); end
  endtask

  task automatic test_read_hit();
    applyStimulus(0, 1'b0, 16'h0013, 16'h0);
    assertCount++; if (sawReadM !== 1'b0) begin failCount++; $display("[TB] FAIL hit_readM: got %0b want 0", sawReadM); end
    assertCount++; if (reqCycles !== 2) begin failCount++; $display("[TB] FAIL hit_latency: got %0d want 2", reqCycles); end
    assertCount++; if (readWord !== 16'h4444) begin failCount++; $display("[TB] FAIL hit_data: got %h want 4444", readWord); end
    assertCount++; if (numAccess[0] !== 16'd2) begin failCount++; $display("[TB] FAIL hit_access: got %0d want 2", numAccess[0]); end
    assertCount++; if (numMiss[0] !== 16'd1) begin failCount++; $display("[TB] FAIL hit_miss: got %0d want 1", numMiss[0]); end
  endtask

  task automatic test_lru();
    logic [15:0] addrs    [6] = '{16'h0010, 16'h0050, 16'h0010, 16'h0090, 16'h0010, 16'h0050};
    bit          expMiss  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] expWords [6] = '{16'h0100, 16'h0500, 16'h0100, 16'h0900, 16'h0100, 16'h0500};
    applyReset();
    useFixedLine = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1'b0, addrs[i], 16'h0);
      assertCount++; if (sawReadM !== expMiss[i]) begin failCount++; $display("[TB] FAIL lru_miss_%0d: got %0b want %0b", i, sawReadM, expMiss[i]); end
      assertCount++; if (readWord !== expWords[i]) begin failCount++; $display("[TB] FAIL lru_data_%0d: got %h want %h", i, readWord, expWords[i]); end
    end
    assertCount++; if (numMiss[0] !== 16'd4) begin failCount++; $display("[TB] FAIL lru_miss_count: got %0d want 4", numMiss[0]); end
    assertCount++; if (numAccess[0] !== 16'd6) begin failCount++; $display("[TB] FAIL lru_access_count: got %0d want 6", numAccess[0]); end
  endtask

  task automatic test_write();
    applyStimulus(0, 1'b1, 16'h0011, 16'hBEEF);
    assertCount++; if (sawWriteM !== 1'b1) begin failCount++; $display("[TB] FAIL wr_writeM: got %0b want 1", sawWriteM); end
    assertCount++; if (seenWriteAddr !== 16'h0011) begin failCount++; $display("[TB] FAIL wr_addressM: got %h want 0011", seenWriteAddr); end
    assertCount++; if (seenWriteLine !== 64'h0000_0000_0000_BEEF) begin failCount++; $display("[TB] FAIL wr_dataM: got %h want 000000000000beef", seenWriteLine); end
    assertCount++; if (sawReadM !== 1'b0) begin failCount++; $display("[TB] FAIL wr_no_fill: got %0b want 0", sawReadM); end
    assertCount++; if (reqCycles !== doneCycle + 1) begin failCount++; $display("[TB] FAIL wr_ready_cycle: got %0d want %0d", reqCycles, doneCycle + 1); end
    assertCount++; if (numMiss[0] !== 16'd4) begin failCount++; $display("[TB] FAIL wr_hit_miss_count: got %0d want 4", numMiss[0]); end
    applyStimulus(0, 1'b0, 16'h0011, 16'h0);
    assertCount++; if (sawReadM !== 1'b0) begin failCount++; $display("[TB] FAIL wr_readback_hit: got %0b want 0", sawReadM); end
    assertCount++; if (readWord !== 16'hBEEF) begin failCount++; $display("[TB] FAIL wr_readback_data: got %h want beef", readWord); end
    applyStimulus(0, 1'b1, 16'h00F0, 16'h1234);
    assertCount++; if (sawReadM !== 1'b0) begin failCount++; $display("[TB] FAIL wmiss_no_fill: got %0b want 0", sawReadM); end
    assertCount++; if (numMiss[0] !== 16'd5) begin failCount++; $display("[TB] FAIL wmiss_miss_count: got %0d want 5", numMiss[0]); end
    applyStimulus(0, 1'b0, 16'h00F0, 16'h0);
    assertCount++; if (sawReadM !== 1'b1) begin failCount++; $display("[TB] FAIL wmiss_no_alloc: got %0b want 1", sawReadM); end
    assertCount++; if (seenFillAddr !== 16'h00F0) begin failCount++; $display("[TB] FAIL wmiss_fill_addr: got %h want 00f0", seenFillAddr); end
    assertCount++; if (numMiss[0] !== 16'd6) begin failCount++; $display("[TB] FAIL wmiss_read_miss_count: got %0d want 6", numMiss[0]); end
    assertCount++; if (numAccess[0] !== 16'd10) begin failCount++; $display("[TB] FAIL wr_access_count: got %0d want 10", numAccess[0]); end
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    applyReset();
    useFixedLine = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    address[0] = 16'h0012;
    readC[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (readM[0]) begin
        seen = 1'b1;
        break;
      end
    end
    assertCount++; if (seen !== 1'b1) begin failCount++; $display("[TB] FAIL midfill_readM_seen: got %0b want 1", seen); end
    assertCount++; if (numAccess[0] !== 16'd1) begin failCount++; $display("[TB] FAIL midfill_access_before: got %0d want 1", numAccess[0]); end
    reset_n = 1'b0;
    #1;
    assertCount++; if (readM[0] !== 1'b0) begin failCount++; $display("[TB] FAIL midfill_readM_drop: got %0b want 0", readM[0]); end
    assertCount++; if (numAccess[0] !== 16'd0) begin failCount++; $display("[TB] FAIL midfill_access_clear: got %0d want 0", numAccess[0]); end
    assertCount++; if (numMiss[0] !== 16'd0) begin failCount++; $display("[TB] FAIL midfill_miss_clear: got %0d want 0", numMiss[0]); end
    readC[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b0, 16'h0012, 16'h0);
    assertCount++; if (sawReadM !== 1'b1) begin failCount++; $display("[TB] FAIL midfill_reread_miss: got %0b want 1", sawReadM); end
    assertCount++; if (readWord !== 16'h3333) begin failCount++; $display("[TB] FAIL midfill_reread_data: got %h want 3333", readWord); end
    assertCount++; if (numMiss[0] !== 16'd1) begin failCount++; $display("[TB] FAIL midfill_reread_count: got %0d want 1", numMiss[0]); end
  endtask

  task automatic test_bypass();
    applyReset();
    useFixedLine = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1'b0, 16'h0020, 16'h0);
      assertCount++; if (sawReadM !== 1'b1) begin failCount++; $display("[TB] FAIL bypass_fill_%0d: got %0b want 1", i, sawReadM); end
      assertCount++; if (readWord !== 16'h0200) begin failCount++; $display("[TB] FAIL bypass_data_%0d: got %h want 0200", i, readWord); end
    end
    assertCount++; if (numMiss[1] !== 16'd2) begin failCount++; $display("[TB] FAIL bypass_miss: got %0d want 2", numMiss[1]); end
    assertCount++; if (numAccess[1] !== 16'd2) begin failCount++; $display("[TB] FAIL bypass_access: got %0d want 2", numAccess[1]); end
  endtask

  // Global time limit in case a wait ever escapes its cycle budget.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    assertCount = 0;
    failCount = 0;
    reset_n = 1'b0;
    tbData = 16'h0;
    memLine = 64'h0;
    useFixedLine = 1'b0;
    seenFillAddr = 16'h0;
    seenWriteAddr = 16'h0;
    seenWriteLine = 64'h0;
    for (int i = 0; i < 2; i++) begin
      readC[i] = 1'b0;
      writeC[i] = 1'b0;
      inputReadyM[i] = 1'b0;
      doneM[i] = 1'b0;
      address[i] = 16'h0;
      tbDataDrive[i] = 1'b0;
      memDrive[i] = 1'b0;
    end
    test_reset();
    test_cold_read();
    test_read_hit();
    test_lru();
    test_write();
    test_reset_mid_fill();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
Parametrised successor to the single-configuration I/D cache. N-way set-associative, write-through, no-write-allocate cache with LRU replacement and configurable sets and line size. Sits between the pipeline memory ports (readC/writeC/readyC) and line-wide main memory (readM/writeM/input_readyM/doneM). One instance serves the I-side and one the D-side.

Parameters:
WORD_SIZE, 16, data and address word width.
LINE_WORDS, 4, words per line. Power of two, 1..8.
SETS, 4, number of sets. Power of two, at least 1.
WAYS, 2, associativity. Power of two, 1..8.
BYPASS, 0, 1 = never hit and never install; every read goes to memory.

Ports:
clk  in  1  clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
readC  in  1  read request; held until readyC
writeC  in  1  write request; held until readyC
address  in  WORD_SIZE  word address of the request
data  inout  WORD_SIZE  write data in; read data out, driven only while readC && readyC, else z
readyC  out  1  one-cycle completion pulse
readM  out  1  line-fill request to memory
writeM  out  1  word write-through request to memory
addressM  out  WORD_SIZE  memory address
dataM  inout  LINE_WORDS*WORD_SIZE  fill line in; write word out on [WORD_SIZE-1:0] (upper bits 0), driven only while writeM, else z
input_readyM  in  1  fill line valid on dataM
doneM  in  1  memory write complete
num_cache_access  out  WORD_SIZE  accepted requests, wraps
num_cache_miss  out  WORD_SIZE  misses, wraps

Behaviour:
- Address split: offset = low log2(LINE_WORDS) bits; index = next log2(SETS) bits; tag = remaining bits. Fill addressM = address with offset bits zeroed. Write addressM = full address.
- Reset (asynchronous, immediate): state IDLE, all valid bits 0, LRU ages to way order, counters 0. readyC, readM, writeM low. data and dataM z.
- States: IDLE, TAG, FILL, RESP, WRITE.
- IDLE: if writeC or readC, latch address and data; num_cache_access+1; go TAG. If both are asserted, write wins.
- TAG, read hit (valid && tag match, BYPASS=0): readyC=1, drive hit word, update LRU, go IDLE. Latency is 2 cycles from request.
- TAG, read miss: num_cache_miss+1, go FILL.
- TAG, write: on hit, update the cached word and LRU. On miss, num_cache_miss+1 and no allocation. Either way go WRITE.
- FILL: readM=1 until input_readyM. On input_readyM, latch dataM into the line buffer. If BYPASS=0, install the line into the victim way (invalid way first, else the LRU way), set valid, make it MRU. Go RESP.
- RESP: readyC=1, drive the buffered word at offset, go IDLE.
- WRITE: writeM=1 until doneM, then readyC=1 in the following cycle (RESP-like), go IDLE.
- input_readyM outside FILL and doneM outside WRITE are ignored.
- The client drops its request in the cycle after readyC. A request still present in IDLE is treated as a new access.
- LRU: per-way log2(WAYS)-bit age. On access, the touched way gets age 0; ways younger than its old age increment. Victim is the way with the maximum age. WAYS=1 always victimises way 0.
- Counters wrap at 2^WORD_SIZE.

Decomposition:
- Shared package/include: state encodings (CACHE_IDLE..CACHE_WRITE) and a clog2 function for field widths.
- Sub-module: cache_lru (per-set age array, inputs set/way/touch, output victim way).
- Tag/valid/data arrays stay in assoc_cache.

Test Plan:
- Cold read 0x0012; memory returns line 0x4444_3333_2222_1111 after 3 cycles -> readM with addressM 0x0010, readyC the cycle after input_readyM, data=0x3333, access=1, miss=1.
- Then read 0x0013 -> no readM, readyC in the 2nd cycle, data=0x4444, access=2, miss=1.
- LRU (WAYS=2, set 0): reads 0x0010 (miss), 0x0050 (miss), 0x0010 (hit), 0x0090 (miss, evicts tag 5), 0x0010 (hit), 0x0050 (miss) -> miss=4.
- Write hit 0x0011 data 0xBEEF -> writeM, addressM 0x0011, dataM[15:0]=0xBEEF; readyC the cycle after doneM; then read 0x0011 hits with 0xBEEF. Write miss 0x00F0 -> no readM, then read 0x00F0 misses.
- Assert reset_n=0 mid-FILL -> readM drops immediately, counters 0; re-read of the previous address misses.
- BYPASS=1: read 0x0020 twice -> two fills, miss=2, access=2.
